// File: rtl/move_executor_if.sv
// Move handshake between the move sequencer and the executor, plus the six stepper driver
// outputs (bit order U D F B L R).
interface move_executor_if;
  logic       start_move;
  logic [3:0] next_move;
  logic       move_done;
  logic       busy;
  logic       bad_move;
  logic [5:0] step;
  logic [5:0] dir;
  logic [5:0] motor_en;

  modport master (
    output start_move, next_move,
    input  move_done, busy, bad_move, step, dir, motor_en
  );

  modport slave (
    input  start_move, next_move,
    output move_done, busy, bad_move, step, dir, motor_en
  );
endinterface

// File: rtl/move_executor.sv
// Executes one quarter turn per accepted move code: direction setup, timed step pulses,
// settle, then a single move_done pulse. Illegal codes are flagged and answered at once.
module move_executor #(
  parameter int unsigned STEPS_PER_QUARTER  = 50,
  parameter int unsigned DIR_SETUP_CYCLES   = 100,
  parameter int unsigned STEP_HIGH_CYCLES   = 1000,
  parameter int unsigned STEP_PERIOD_CYCLES = 20000,
  parameter int unsigned SETTLE_CYCLES      = 100000
) (
  input  logic          clock_i,
  input  logic          reset_i,
  move_executor_if.slave mv
);

  localparam int NUM_FACES = 6;
  localparam int CW        = $clog2(STEPS_PER_QUARTER + 1);

  // Timer loads are duration-1 so a phase lasts exactly its cycle count.
  localparam logic [31:0] DIR_T    = 32'(DIR_SETUP_CYCLES - 1);
  localparam logic [31:0] HIGH_T   = 32'(STEP_HIGH_CYCLES - 1);
  localparam logic [31:0] LOW_T    = 32'(STEP_PERIOD_CYCLES - STEP_HIGH_CYCLES - 1);
  localparam logic [31:0] SETTLE_T = 32'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS_PER_QUARTER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIR_SETUP, S_STEP_HIGH, S_STEP_LOW, S_SETTLE, S_REJECT, S_DONE
  } state_t;

  state_t                 state_q;
  logic [31:0]            timer_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_FACES-1:0]   face_oh_q;
  logic [NUM_FACES-1:0]   step_q;
  logic [NUM_FACES-1:0]   dir_q;
  logic [NUM_FACES-1:0]   en_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   bad_q;

  logic                   legal;
  logic                   cw;
  logic [2:0]             face;
  logic [NUM_FACES-1:0]   face_oh;
  logic                   tmr_zero;

  // 1..6 clockwise, 7..12 counter-clockwise on the same faces, everything else illegal.
  always_comb begin
    legal = 1'b0;
    cw    = 1'b0;
    face  = 3'd0;
    if (mv.next_move >= 4'd1 && mv.next_move <= 4'd6) begin
      legal = 1'b1;
      cw    = 1'b1;
      face  = 3'(mv.next_move - 4'd1);
    end else if (mv.next_move >= 4'd7 && mv.next_move <= 4'd12) begin
      legal = 1'b1;
      face  = 3'(mv.next_move - 4'd7);
    end
  end

  for (genvar g = 0; g < NUM_FACES; g++) begin : g_face
    assign face_oh[g] = (face == 3'(g));
  end

  assign tmr_zero = (timer_q == 32'd0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      face_oh_q <= '0;
      step_q    <= '0;
      dir_q     <= '0;
      en_q      <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      bad_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mv.start_move) begin
            busy_q <= 1'b1;
            if (legal) begin
              face_oh_q <= face_oh;
              en_q      <= face_oh;
              dir_q     <= cw ? (dir_q | face_oh) : (dir_q & ~face_oh);
              timer_q   <= DIR_T;
              state_q   <= S_DIR_SETUP;
            end else begin
              bad_q   <= 1'b1;
              state_q <= S_REJECT;
            end
          end
        end
        S_DIR_SETUP: begin
          if (tmr_zero) begin
            cnt_q   <= '0;
            step_q  <= face_oh_q;
            timer_q <= HIGH_T;
            state_q <= S_STEP_HIGH;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_STEP_HIGH: begin
          if (tmr_zero) begin
            step_q  <= '0;
            timer_q <= LOW_T;
            state_q <= S_STEP_LOW;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_STEP_LOW: begin
          if (tmr_zero) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
              timer_q <= SETTLE_T;
              state_q <= S_SETTLE;
            end else begin
              step_q  <= face_oh_q;
              timer_q <= HIGH_T;
              state_q <= S_STEP_HIGH;
            end
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_SETTLE: begin
          if (tmr_zero) begin
            en_q    <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_REJECT: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          // start_move here is deliberately dropped; the initiator must wait for IDLE.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mv.step      = step_q;
  assign mv.dir       = dir_q;
  assign mv.motor_en  = en_q;
  assign mv.move_done = done_q;
  assign mv.busy      = busy_q;
  assign mv.bad_move  = bad_q;

  a_step_onehot: assert property (@(posedge clock_i) disable iff (reset_i) $onehot0(step_q));
  a_en_onehot:   assert property (@(posedge clock_i) disable iff (reset_i) $onehot0(en_q));
  a_done_single: assert property (@(posedge clock_i) disable iff (reset_i) done_q |=> !done_q);

endmodule

// File: tb/tb_move_executor.sv
// Scoreboard bench for move_executor with shortened timing (4 steps, 2/4 cycle pulses).
module tb_move_executor;
  localparam int STEPS  = 4;
  localparam int DSET   = 2;
  localparam int HIGH   = 2;
  localparam int PERIOD = 4;
  localparam int SETTLE = 3;
  localparam int LAT    = DSET + STEPS * PERIOD + SETTLE + 1;

  typedef struct {
    int         done_rel;
    int         done_cnt;
    int         bad_rel;
    int         bad_cnt;
    logic [5:0] en_or;
    logic [5:0] step_or;
    int         pulses;
    int         first_step;
    int         terr;
    int         busy_post;
    int         busy_gap;
    logic [5:0] en_done;
    logic [5:0] en_pre;
    logic [5:0] dir_face;
    int         dbl;
    int         multi;
    logic [14:0] rst_snap;
    int         busy_after_rst;
  } res_t;

  logic clk;
  logic rst;
  move_executor_if mif();

  move_executor #(
    .STEPS_PER_QUARTER (STEPS),
    .DIR_SETUP_CYCLES  (DSET),
    .STEP_HIGH_CYCLES  (HIGH),
    .STEP_PERIOD_CYCLES(PERIOD),
    .SETTLE_CYCLES     (SETTLE)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .mv     (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  bit   seq_done;

  function automatic res_t model(input logic [3:0] code);
    res_t r;
    logic [5:0] oh;
    bit lg, c;
    lg = (code >= 1 && code <= 12);
    c  = (code >= 1 && code <= 6);
    oh = 6'd0;
    if (code >= 1 && code <= 6) oh[code - 1] = 1'b1;
    else if (code >= 7 && code <= 12) oh[code - 7] = 1'b1;
    r.done_cnt = 1; r.busy_post = 0; r.busy_gap = 0; r.dbl = 0; r.multi = 0; r.terr = 0;
    r.en_done = 6'd0; r.rst_snap = '0; r.busy_after_rst = 0;
    r.done_rel   = lg ? LAT : 2;
    r.bad_rel    = lg ? -1 : 1;
    r.bad_cnt    = lg ? 0 : 1;
    r.en_or      = oh;
    r.step_or    = oh;
    r.en_pre     = oh;
    r.pulses     = lg ? STEPS : 0;
    r.first_step = lg ? DSET + 1 : -1;
    r.dir_face   = c ? oh : 6'd0;
    return r;
  endfunction

  // Drives one start_move and records what the DUT does over max_rel cycles.
  // Cycle 1 is the cycle right after the edge that samples start_move.
  task automatic run_move(input logic [3:0] code, input int max_rel, input int inj_rel,
                          input logic [3:0] inj_code, input bit inj_done, input int rst_rel);
    res_t o;
    int hi_run, lo_run;
    bit prev_done;
    o.done_rel = -1; o.done_cnt = 0; o.bad_rel = -1; o.bad_cnt = 0; o.en_or = 0; o.step_or = 0;
    o.pulses = 0; o.first_step = -1; o.terr = 0; o.busy_post = 0; o.busy_gap = 0; o.en_done = 0;
    o.en_pre = 0; o.dir_face = 0; o.dbl = 0; o.multi = 0; o.rst_snap = '0; o.busy_after_rst = 0;
    hi_run = 0; lo_run = 0; prev_done = 0;
    @(negedge clk);
    mif.start_move = 1'b1;
    mif.next_move  = code;
    for (int rel = 1; rel <= max_rel; rel++) begin
      @(negedge clk);
      mif.start_move = 1'b0;
      rst = 1'b0;
      if (mif.move_done) begin
        o.done_cnt++;
        if (o.done_rel < 0) begin
          o.done_rel = rel;
          o.en_done  = mif.motor_en;
          o.dir_face = mif.dir & o.en_pre;
        end
      end
      if (prev_done && mif.move_done) o.dbl++;
      prev_done = mif.move_done;
      if (o.done_rel < 0 && !mif.move_done) o.en_pre = mif.motor_en;
      if (o.done_rel > 0 && rel > o.done_rel && mif.busy) o.busy_post++;
      if (o.done_rel < 0 && !mif.busy && (rst_rel < 0 || rel <= rst_rel)) o.busy_gap++;
      if (mif.bad_move) begin
        o.bad_cnt++;
        if (o.bad_rel < 0) o.bad_rel = rel;
      end
      o.en_or   |= mif.motor_en;
      o.step_or |= mif.step;
      if (!$onehot0(mif.step) || !$onehot0(mif.motor_en)) o.multi++;
      if (mif.step != 6'd0) begin
        if (hi_run == 0) begin
          o.pulses++;
          if (o.first_step < 0) o.first_step = rel;
          if (o.pulses > 1 && lo_run != PERIOD - HIGH) o.terr++;
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (hi_run > 0) begin
          if (hi_run != HIGH) o.terr++;
          lo_run = 0;
        end
        hi_run = 0;
        lo_run++;
      end
      if (rst_rel > 0 && rel == rst_rel + 1)
        o.rst_snap = {mif.step, mif.motor_en, mif.busy, mif.move_done, mif.bad_move};
      if (rst_rel > 0 && rel > rst_rel && mif.busy) o.busy_after_rst++;
      if (rel == inj_rel || (inj_done && mif.move_done)) begin
        mif.start_move = 1'b1;
        mif.next_move  = inj_code;
      end
      if (rel == rst_rel) rst = 1'b1;
    end
    mif.start_move = 1'b0;
    rst = 1'b0;
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mif.start_move = 1'b1;
    mif.next_move  = 4'd1;
    repeat (3) @(negedge clk);
    n_chk++; if (mif.step !== 6'd0) $display("FAIL reset_step got %b exp 000000", mif.step); else n_pass++;
    n_chk++; if (mif.motor_en !== 6'd0) $display("FAIL reset_en got %b exp 000000", mif.motor_en); else n_pass++;
    n_chk++; if (mif.dir !== 6'd0) $display("FAIL reset_dir got %b exp 000000", mif.dir); else n_pass++;
    n_chk++; if ({mif.busy, mif.move_done, mif.bad_move} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {mif.busy, mif.move_done, mif.bad_move}); else n_pass++;
    mif.start_move = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (mif.busy !== 1'b0) $display("FAIL reset_start_dropped busy got %b exp 0", mif.busy); else n_pass++;
  endtask

  task automatic test_cw_u;
    res_t e, o;
    exp_q.push_back(model(4'd1));
    run_move(4'd1, LAT + 4, -1, 4'd0, 1'b0, -1);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_chk++; if (o.done_rel !== e.done_rel) $display("FAIL u_done_cycle got %0d exp %0d", o.done_rel, e.done_rel); else n_pass++;
    n_chk++; if (o.done_cnt !== 1 || o.dbl !== 0) $display("FAIL u_done_count got %0d dbl %0d exp 1 dbl 0", o.done_cnt, o.dbl); else n_pass++;
    n_chk++; if (o.pulses !== e.pulses || o.terr !== 0) $display("FAIL u_pulses got %0d terr %0d exp %0d terr 0", o.pulses, o.terr, e.pulses); else n_pass++;
    n_chk++; if (o.first_step !== e.first_step) $display("FAIL u_first_step got %0d exp %0d", o.first_step, e.first_step); else n_pass++;
    n_chk++; if (o.en_or !== e.en_or || o.en_pre !== e.en_pre) $display("FAIL u_motor_en got %b/%b exp %b", o.en_or, o.en_pre, e.en_or); else n_pass++;
    n_chk++; if (o.dir_face !== e.dir_face) $display("FAIL u_dir got %b exp %b", o.dir_face, e.dir_face); else n_pass++;
    n_chk++; if (o.en_done !== 6'd0) $display("FAIL u_en_in_done got %b exp 000000", o.en_done); else n_pass++;
    n_chk++; if (o.busy_gap !== 0 || o.busy_post !== 0) $display("FAIL u_busy gap %0d post %0d exp 0 0", o.busy_gap, o.busy_post); else n_pass++;
  endtask

  task automatic test_ccw_f;
    res_t e, o;
    exp_q.push_back(model(4'd3));
    run_move(4'd3, LAT + 2, -1, 4'd0, 1'b0, -1);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_chk++; if (o.dir_face !== e.dir_face) $display("FAIL f_cw_dir got %b exp %b", o.dir_face, e.dir_face); else n_pass++;
    exp_q.push_back(model(4'd9));
    run_move(4'd9, LAT + 2, -1, 4'd0, 1'b0, -1);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_chk++; if (o.dir_face !== e.dir_face) $display("FAIL f_ccw_dir got %b exp %b", o.dir_face, e.dir_face); else n_pass++;
    n_chk++; if (o.step_or !== e.step_or || o.multi !== 0) $display("FAIL f_step_bits got %b multi %0d exp %b", o.step_or, o.multi, e.step_or); else n_pass++;
    n_chk++; if (o.en_or !== e.en_or) $display("FAIL f_motor_en got %b exp %b", o.en_or, e.en_or); else n_pass++;
    n_chk++; if (o.pulses !== e.pulses || o.terr !== 0) $display("FAIL f_pulses got %0d terr %0d exp %0d", o.pulses, o.terr, e.pulses); else n_pass++;
    n_chk++; if (o.done_rel !== e.done_rel) $display("FAIL f_done_cycle got %0d exp %0d", o.done_rel, e.done_rel); else n_pass++;
  endtask

  task automatic test_illegal;
    res_t e, o;
    logic [3:0] codes [2];
    codes[0] = 4'd0;
    codes[1] = 4'd14;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(codes[i]));
      run_move(codes[i], 5, -1, 4'd0, 1'b0, -1);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_chk++; if (o.bad_rel !== e.bad_rel || o.bad_cnt !== e.bad_cnt) $display("FAIL bad_%0d bad_move cycle %0d cnt %0d exp %0d cnt %0d", codes[i], o.bad_rel, o.bad_cnt, e.bad_rel, e.bad_cnt); else n_pass++;
      n_chk++; if (o.done_rel !== e.done_rel || o.done_cnt !== 1) $display("FAIL bad_%0d done cycle %0d cnt %0d exp %0d cnt 1", codes[i], o.done_rel, o.done_cnt, e.done_rel); else n_pass++;
      n_chk++; if (o.step_or !== 6'd0 || o.en_or !== 6'd0) $display("FAIL bad_%0d activity step %b en %b exp 0", codes[i], o.step_or, o.en_or); else n_pass++;
      n_chk++; if (o.busy_gap !== 0 || o.busy_post !== 0) $display("FAIL bad_%0d busy gap %0d post %0d exp 0 0", codes[i], o.busy_gap, o.busy_post); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    res_t e, o;
    exp_q.push_back(model(4'd6));
    run_move(4'd6, LAT + 5, 5, 4'd1, 1'b1, -1);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_chk++; if (o.en_or !== e.en_or || o.step_or !== e.step_or) $display("FAIL b2b_faces en %b step %b exp %b", o.en_or, o.step_or, e.en_or); else n_pass++;
    n_chk++; if (o.done_cnt !== 1 || o.done_rel !== e.done_rel) $display("FAIL b2b_done cnt %0d cycle %0d exp 1 cycle %0d", o.done_cnt, o.done_rel, e.done_rel); else n_pass++;
    n_chk++; if (o.busy_post !== 0) $display("FAIL b2b_busy_after_done got %0d exp 0", o.busy_post); else n_pass++;
  endtask

  task automatic test_reset_mid_move;
    res_t e, o;
    run_move(4'd3, 20, -1, 4'd0, 1'b0, 8);
    o = obs_q.pop_front();
    n_chk++; if (o.rst_snap !== 15'd0) $display("FAIL rst_mid_outputs got %h exp 0", o.rst_snap); else n_pass++;
    n_chk++; if (o.done_cnt !== 0) $display("FAIL rst_mid_no_done got %0d exp 0", o.done_cnt); else n_pass++;
    n_chk++; if (o.busy_after_rst !== 0) $display("FAIL rst_mid_busy got %0d exp 0", o.busy_after_rst); else n_pass++;
    n_chk++; if (o.pulses !== 2 || o.en_or !== 6'b000100) $display("FAIL rst_mid_partial pulses %0d en %b exp 2 000100", o.pulses, o.en_or); else n_pass++;
    exp_q.push_back(model(4'd3));
    run_move(4'd3, LAT + 2, -1, 4'd0, 1'b0, -1);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_chk++; if (o.done_rel !== e.done_rel || o.pulses !== e.pulses) $display("FAIL rst_fresh cycle %0d pulses %0d exp %0d %0d", o.done_rel, o.pulses, e.done_rel, e.pulses); else n_pass++;
  endtask

  task automatic test_sequence;
    res_t e, o;
    logic [3:0] seq [3];
    int ndone;
    seq[0] = 4'd2; seq[1] = 4'd8; seq[2] = 4'd12;
    ndone = 0;
    seq_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(seq[i]));
      run_move(seq[i], LAT + 1, -1, 4'd0, 1'b0, -1);
    end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      ndone += o.done_cnt;
      n_chk++; if (o.en_or !== e.en_or || o.dir_face !== e.dir_face) $display("FAIL seq_%0d face en %b dir %b exp %b dir %b", i, o.en_or, o.dir_face, e.en_or, e.dir_face); else n_pass++;
      n_chk++; if (o.done_rel !== e.done_rel) $display("FAIL seq_%0d done cycle %0d exp %0d", i, o.done_rel, e.done_rel); else n_pass++;
    end
    if (ndone == 3) seq_done = 1'b1;
    n_chk++; if (seq_done !== 1'b1) $display("FAIL seq_done got %b (%0d dones) exp 1", seq_done, ndone); else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    mif.start_move = 1'b0;
    mif.next_move  = 4'd0;
    test_reset();
    test_cw_u();
    test_ccw_f();
    test_illegal();
    test_back_to_back();
    test_reset_mid_move();
    test_sequence();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
